mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-response stage; sits directly downstream of the pre-memory (request) stage and upstream of WB.
//  Holds one instruction. For loads/stores whose request was accepted upstream, it waits for data_data_ok
//  (and buffers rdata), aligns and extends load data, and merges LWL/LWR. It provides the forwarding bus,
//  passes exceptions through to WB, and discards data responses orphaned by a pipeline flush.
// PARAMETERS
//  CANCEL_W     2    width of orphan-response counter (max 2**CANCEL_W-1 outstanding discards)
// PORTS
//  clk               in   1      clock; all state updates on posedge
//  reset             in   1      synchronous, active-high
//  ws_allowin        in   1      WB can accept this cycle
//  ms_allowin        out  1      this stage can accept from pre-mem
//  pms_to_ms_bus     in   struct valid, load_op[2:0], c0_op, c0_addr, req_ok, res_from_mem, res_to_mem, rf_we, dest[4:0], result[31:0], pc, exception, phy_addr[31:0], tlb_op, cache_op
//  ms_to_ws_bus      out  struct valid, c0_op, c0_addr, rf_we, dest, final_result[31:0], pc, exception, tlb_op, cache_op
//  ms_forward_bus    out  struct {op_mfc0, load_pending, dest[4:0], final_result[31:0]}
//  wr_disable        in   1      a younger-than-WB stage holds an exception/eret (from WB)
//  ms_wr_disable     out  1      ms_valid & exception.ex
//  pipeline_flush    in   struct .flush clears this stage
//  data_data_ok      in   1      response beat for oldest outstanding data request
//  data_rdata        in   32     load data (don't-care for stores)
// BEHAVIOUR
//  load_op encoding: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR; 7 reserved, treated as LW.
//  Registers: ms_valid, bus_r (captured when ms_allowin & pms_to_ms_bus.valid), data_buf[31:0], data_got, cancel_cnt.
//  Reset: ms_valid=0, data_got=0, cancel_cnt=0; hence ms_to_ws_bus.valid=0, ms_wr_disable=0, forward op_mfc0/load_pending=0, dest=0.
//  need_data = bus_r.req_ok & (res_from_mem | res_to_mem) & !exception.ex.
//  ms_ready_go = !need_data | data_got | (data_data_ok & cancel_cnt==0).
//  ms_allowin = !ms_valid | (ms_ready_go & ws_allowin). ms_to_ws valid = ms_valid & ms_ready_go.
//  ms_valid: flush -> 0; else if ms_allowin -> pms_to_ms_bus.valid.
//  Response routing: data_data_ok with cancel_cnt>0 -> cancel_cnt-1, data dropped.
//    Otherwise, if ms_valid & need_data & !data_got, the beat belongs to this instruction. If it arrives in the same
//    cycle it leaves (ws_allowin=1), it is used combinationally; otherwise it is latched into data_buf with data_got=1.
//    data_got clears when the instruction leaves or on flush.
//  Flush: if ms_valid & need_data & !data_got & !(data_data_ok & cancel_cnt==0), cancel_cnt+1. If the incoming
//    pms_to_ms_bus.valid & req_ok in the same cycle, a further +1. Same-cycle increment and decrement net out.
//    Overflow beyond 2**CANCEL_W-1 is a design error (assertion).
//  Load data (addr = bus_r.phy_addr[1:0], rd = live or buffered data):
//    LB/LBU: byte rd[8*addr+:8], sign/zero-extended. LH/LHU: half rd[16*addr[1]+:16], sign/zero-extended.
//    LWL: merge high bytes of rd into old rt (bus_r.result). addr 0 -> {rd[7:0],rt[23:0]}, addr 3 -> rd.
//    LWR: addr 0 -> rd, addr 3 -> {rt[31:8],rd[31:24]}.
//  final_result = res_from_mem ? aligned load data : bus_r.result.
//  Stores: wait for data_data_ok (write ack). final_result = bus_r.result. rf_we is carried through (0 for stores).
//  Exception (bus_r.exception.ex): no wait, passes with rf_we forced 0. ms_wr_disable asserts while valid.
//  Forward: op_mfc0 = c0_op[2] & ms_valid; load_pending = res_from_mem & ms_valid & !ms_ready_go;
//    dest = bus_r.dest & {5{ms_valid}}.
//  Latency: a non-memory op spends 1 cycle. A load spends 1 cycle plus the cycles until data_data_ok.
//  Reset mid-wait: all state clears, including cancel_cnt. The memory side is reset in the same cycle.
// TESTING
//  LB, phy_addr[1:0]=3, rdata=0x80112233, ok 2 cycles after entry -> ws valid in cycle 3, result 0xFFFFFF80.
//  LHU addr[1:0]=2, rdata=0xBEEF1234 -> 0x0000BEEF. LWL addr 1, rt=0xAABBCCDD, rdata=0x11223344 -> 0x3344CCDD.
//  Load, data_ok while ws_allowin=0 for 3 cycles -> data_buf holds value, exactly one ws valid beat, correct data.
//  Flush while load waiting, then data_ok(0xDEAD), then new LW with data_ok(0x1234) -> only 0x1234 delivered, cancel_cnt back to 0.
//  Exception in (exccode AdEL, req_ok=0) -> ws valid next cycle, rf_we=0, ms_wr_disable=1, no data_ok needed.
//  Reset asserted during a pending load with cancel_cnt=1 -> next cycle ms_valid=0, cancel_cnt=0, all outputs at reset values.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bus types and handshake bundle between the pre-memory stage, the memory-response stage and WB.
// The environment side (pre-mem, WB, memory port) uses the master modport; mem_stage uses slave.
package mem_stage_pkg;

  typedef struct packed {
    logic       ex;
    logic [4:0] exccode;
  } exc_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  load_op;
    logic [2:0]  c0_op;
    logic [7:0]  c0_addr;
    logic        req_ok;
    logic        res_from_mem;
    logic        res_to_mem;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
    exc_t        exception;
    logic [31:0] phy_addr;
    logic [1:0]  tlb_op;
    logic [4:0]  cache_op;
  } pms_to_ms_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  c0_op;
    logic [7:0]  c0_addr;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    exc_t        exception;
    logic [1:0]  tlb_op;
    logic [4:0]  cache_op;
  } ms_to_ws_t;

  typedef struct packed {
    logic        op_mfc0;
    logic        load_pending;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_forward_t;

  typedef struct packed {
    logic flush;
  } flush_t;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

endpackage

interface mem_stage_if;
  import mem_stage_pkg::*;

  logic        ws_allowin;
  logic        ms_allowin;
  pms_to_ms_t  pms_to_ms_bus;
  ms_to_ws_t   ms_to_ws_bus;
  ms_forward_t ms_forward_bus;
  logic        wr_disable;
  logic        ms_wr_disable;
  flush_t      pipeline_flush;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output ws_allowin, pms_to_ms_bus, wr_disable, pipeline_flush, data_data_ok, data_rdata,
    input  ms_allowin, ms_to_ws_bus, ms_forward_bus, ms_wr_disable
  );

  modport slave (
    input  ws_allowin, pms_to_ms_bus, wr_disable, pipeline_flush, data_data_ok, data_rdata,
    output ms_allowin, ms_to_ws_bus, ms_forward_bus, ms_wr_disable
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-response stage: holds one instruction, collects its data response (live or buffered),
// aligns/merges load data, and swallows responses orphaned by a pipeline flush.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int CANCEL_W = 2
) (
  input  logic     clk,
  input  logic     reset,
  mem_stage_if.slave ms_if
);

  logic                ms_valid_q, ms_valid_d;
  pms_to_ms_t          bus_q, bus_d;
  logic [31:0]         data_buf_q, data_buf_d;
  logic                data_got_q, data_got_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;
  logic [CANCEL_W:0]   cancel_sum;

  logic        need_data;
  logic        data_ok_mine;
  logic        ms_ready_go;
  logic        ms_allowin;
  logic        ms_leave;
  logic        flush;
  logic        cancel_inc_cur, cancel_inc_new, cancel_dec;
  logic [31:0] rd, rt, load_data, final_result;
  logic [1:0]  addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign flush        = ms_if.pipeline_flush.flush;
  assign need_data    = bus_q.req_ok & (bus_q.res_from_mem | bus_q.res_to_mem) & ~bus_q.exception.ex;
  assign data_ok_mine = ms_if.data_data_ok & (cancel_cnt_q == '0);
  assign ms_ready_go  = ~need_data | data_got_q | data_ok_mine;
  assign ms_allowin   = ~ms_valid_q | (ms_ready_go & ms_if.ws_allowin);
  assign ms_leave     = ms_valid_q & ms_ready_go & ms_if.ws_allowin;

  // Orphan accounting: the flushed instruction's outstanding beat, plus a request accepted
  // upstream in the flush cycle, will each still return a beat that must be dropped.
  assign cancel_inc_cur = flush & ms_valid_q & need_data & ~data_got_q & ~data_ok_mine;
  assign cancel_inc_new = flush & ms_if.pms_to_ms_bus.valid & ms_if.pms_to_ms_bus.req_ok;
  assign cancel_dec     = ms_if.data_data_ok & (cancel_cnt_q != '0);
  assign cancel_sum     = {1'b0, cancel_cnt_q}
                        + {{CANCEL_W{1'b0}}, cancel_inc_cur}
                        + {{CANCEL_W{1'b0}}, cancel_inc_new}
                        - {{CANCEL_W{1'b0}}, cancel_dec};
  assign cancel_cnt_d   = cancel_sum[CANCEL_W-1:0];

  always_comb begin
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    data_buf_d = data_buf_q;
    data_got_d = data_got_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = ms_if.pms_to_ms_bus.valid;
    end
    if (ms_allowin & ms_if.pms_to_ms_bus.valid) begin
      bus_d = ms_if.pms_to_ms_bus;
    end
    if (flush | ms_leave) begin
      data_got_d = 1'b0;
    end else if (ms_valid_q & need_data & ~data_got_q & data_ok_mine) begin
      data_got_d = 1'b1;
      data_buf_d = ms_if.data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      data_got_q   <= 1'b0;
      cancel_cnt_q <= '0;
      bus_q        <= '0;
      data_buf_q   <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      data_got_q   <= data_got_d;
      cancel_cnt_q <= cancel_cnt_d;
      bus_q        <= bus_d;
      data_buf_q   <= data_buf_d;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !cancel_sum[CANCEL_W]);

  assign rd   = data_got_q ? data_buf_q : ms_if.data_rdata;
  assign rt   = bus_q.result;
  assign addr = bus_q.phy_addr[1:0];

  always_comb begin
    byte_sel = rd[7:0];
    case (addr)
      2'd0: byte_sel = rd[7:0];
      2'd1: byte_sel = rd[15:8];
      2'd2: byte_sel = rd[23:16];
      2'd3: byte_sel = rd[31:24];
      default: byte_sel = rd[7:0];
    endcase
  end

  assign half_sel = addr[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    load_data = rd;
    case (bus_q.load_op)
      LD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: load_data = {24'd0, byte_sel};
      LD_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU: load_data = {16'd0, half_sel};
      LD_LWL: begin
        case (addr)
          2'd0:    load_data = {rd[7:0],  rt[23:0]};
          2'd1:    load_data = {rd[15:0], rt[15:0]};
          2'd2:    load_data = {rd[23:0], rt[7:0]};
          default: load_data = rd;
        endcase
      end
      LD_LWR: begin
        case (addr)
          2'd0:    load_data = rd;
          2'd1:    load_data = {rt[31:24], rd[31:8]};
          2'd2:    load_data = {rt[31:16], rd[31:16]};
          default: load_data = {rt[31:8],  rd[31:24]};
        endcase
      end
      default: load_data = rd;
    endcase
  end

  assign final_result = bus_q.res_from_mem ? load_data : bus_q.result;

  assign ms_if.ms_allowin                  = ms_allowin;
  assign ms_if.ms_to_ws_bus.valid          = ms_valid_q & ms_ready_go;
  assign ms_if.ms_to_ws_bus.c0_op          = bus_q.c0_op;
  assign ms_if.ms_to_ws_bus.c0_addr        = bus_q.c0_addr;
  assign ms_if.ms_to_ws_bus.rf_we          = bus_q.rf_we & ~bus_q.exception.ex;
  assign ms_if.ms_to_ws_bus.dest           = bus_q.dest;
  assign ms_if.ms_to_ws_bus.final_result   = final_result;
  assign ms_if.ms_to_ws_bus.pc             = bus_q.pc;
  assign ms_if.ms_to_ws_bus.exception      = bus_q.exception;
  assign ms_if.ms_to_ws_bus.tlb_op         = bus_q.tlb_op;
  assign ms_if.ms_to_ws_bus.cache_op       = bus_q.cache_op;

  assign ms_if.ms_forward_bus.op_mfc0      = bus_q.c0_op[2] & ms_valid_q;
  assign ms_if.ms_forward_bus.load_pending = bus_q.res_from_mem & ms_valid_q & ~ms_ready_go;
  assign ms_if.ms_forward_bus.dest         = bus_q.dest & {5{ms_valid_q}};
  assign ms_if.ms_forward_bus.final_result = final_result;

  assign ms_if.ms_wr_disable = ms_valid_q & bus_q.exception.ex;

  // wr_disable is part of the WB handshake but nothing in this stage depends on it
  logic unused_bits;
  assign unused_bits = &{1'b0, ms_if.wr_disable, bus_q.valid, bus_q.phy_addr[31:2]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, store ack, back-pressure buffering,
// flush orphan discard, exception pass-through and reset during a pending load.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  mem_stage_if bus_if ();

  mem_stage #(.CANCEL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .ms_if (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic pms_to_ms_t mk_req(input logic [2:0] op, input logic from_mem,
                                        input logic to_mem, input logic [4:0] dest,
                                        input logic [31:0] rt, input logic [31:0] paddr);
    pms_to_ms_t r;
    r              = '0;
    r.valid        = 1'b1;
    r.load_op      = op;
    r.req_ok       = from_mem | to_mem;
    r.res_from_mem = from_mem;
    r.res_to_mem   = to_mem;
    r.rf_we        = ~to_mem;
    r.dest         = dest;
    r.result       = rt;
    r.pc           = 32'hBFC0_0100;
    r.phy_addr     = paddr;
    return r;
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  a;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs [9];
  pms_to_ms_t req;

  initial begin
    vecs[0] = '{LD_LHU, 2'd2, 32'h0,         32'hBEEF1234, 32'h0000BEEF};
    vecs[1] = '{LD_LWL, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD};
    vecs[2] = '{LD_LWL, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'h11223344};
    vecs[3] = '{LD_LWR, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'hAABBCC11};
    vecs[4] = '{LD_LWR, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'hAA112233};
    vecs[5] = '{LD_LWR, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h11223344};
    vecs[6] = '{LD_LH,  2'd0, 32'h0,         32'h12348001, 32'hFFFF8001};
    vecs[7] = '{LD_LBU, 2'd1, 32'h0,         32'h00009A00, 32'h0000009A};
    vecs[8] = '{3'd7,   2'd0, 32'h0,         32'h76543210, 32'h76543210};

    reset                  = 1'b1;
    bus_if.ws_allowin      = 1'b1;
    bus_if.pms_to_ms_bus   = '0;
    bus_if.wr_disable      = 1'b0;
    bus_if.pipeline_flush  = '0;
    bus_if.data_data_ok    = 1'b0;
    bus_if.data_rdata      = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_ws_valid", bus_if.ms_to_ws_bus.valid, 0);
    chk("rst_wr_dis", bus_if.ms_wr_disable, 0);
    chk("rst_fwd_mfc0", bus_if.ms_forward_bus.op_mfc0, 0);
    chk("rst_fwd_pend", bus_if.ms_forward_bus.load_pending, 0);
    chk("rst_fwd_dest", bus_if.ms_forward_bus.dest, 0);
    chk("rst_allowin", bus_if.ms_allowin, 1);

    // LB addr 3, response two cycles after entry
    bus_if.pms_to_ms_bus = mk_req(LD_LB, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0000_1003);
    step();
    bus_if.pms_to_ms_bus = '0;
    #1;
    chk("lb_wait_valid", bus_if.ms_to_ws_bus.valid, 0);
    chk("lb_pending", bus_if.ms_forward_bus.load_pending, 1);
    chk("lb_fwd_dest", bus_if.ms_forward_bus.dest, 5);
    chk("lb_allowin", bus_if.ms_allowin, 0);
    step();
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h80112233;
    #1;
    chk("lb_valid", bus_if.ms_to_ws_bus.valid, 1);
    chk("lb_result", bus_if.ms_to_ws_bus.final_result, 32'hFFFFFF80);
    chk("lb_rf_we", bus_if.ms_to_ws_bus.rf_we, 1);
    step();
    bus_if.data_data_ok = 1'b0;
    #1;
    chk("lb_left", bus_if.ms_to_ws_bus.valid, 0);

    foreach (vecs[i]) begin
      bus_if.pms_to_ms_bus = mk_req(vecs[i].op, 1'b1, 1'b0, 5'd7, vecs[i].rt, {30'h40, vecs[i].a});
      step();
      bus_if.pms_to_ms_bus = '0;
      bus_if.data_data_ok  = 1'b1;
      bus_if.data_rdata    = vecs[i].rd;
      #1;
      chk($sformatf("ld%0d_valid", i), bus_if.ms_to_ws_bus.valid, 1);
      chk($sformatf("ld%0d_result", i), bus_if.ms_to_ws_bus.final_result, vecs[i].exp);
      step();
      bus_if.data_data_ok = 1'b0;
    end

    // store waits for its write ack
    bus_if.pms_to_ms_bus = mk_req(LD_LW, 1'b0, 1'b1, 5'd0, 32'h0000_0099, 32'h0000_2000);
    step();
    bus_if.pms_to_ms_bus = '0;
    #1;
    chk("st_wait", bus_if.ms_to_ws_bus.valid, 0);
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'hFFFF_FFFF;
    #1;
    chk("st_valid", bus_if.ms_to_ws_bus.valid, 1);
    chk("st_result", bus_if.ms_to_ws_bus.final_result, 32'h99);
    chk("st_rf_we", bus_if.ms_to_ws_bus.rf_we, 0);
    step();
    bus_if.data_data_ok = 1'b0;

    // data arrives while WB stalls: buffered, delivered once
    bus_if.ws_allowin    = 1'b0;
    bus_if.pms_to_ms_bus = mk_req(LD_LW, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0000_3000);
    step();
    bus_if.pms_to_ms_bus = '0;
    bus_if.data_data_ok  = 1'b1;
    bus_if.data_rdata    = 32'hCAFEF00D;
    step();
    bus_if.data_data_ok = 1'b0;
    bus_if.data_rdata   = 32'h0;
    #1;
    chk("bp_data_got", dut.data_got_q, 1);
    chk("bp_data_buf", dut.data_buf_q, 32'hCAFEF00D);
    chk("bp_valid", bus_if.ms_to_ws_bus.valid, 1);
    chk("bp_pending", bus_if.ms_forward_bus.load_pending, 0);
    step();
    step();
    bus_if.ws_allowin = 1'b1;
    #1;
    chk("bp_result", bus_if.ms_to_ws_bus.final_result, 32'hCAFEF00D);
    step();
    chk("bp_one_beat", bus_if.ms_to_ws_bus.valid, 0);
    chk("bp_got_clr", dut.data_got_q, 0);

    // flush while waiting: orphan 0xDEAD discarded, next load gets 0x1234
    bus_if.pms_to_ms_bus = mk_req(LD_LW, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0000_4000);
    step();
    bus_if.pms_to_ms_bus = '0;
    bus_if.pipeline_flush.flush = 1'b1;
    step();
    bus_if.pipeline_flush.flush = 1'b0;
    #1;
    chk("fl_cancel1", dut.cancel_cnt_q, 1);
    chk("fl_empty", bus_if.ms_to_ws_bus.valid, 0);
    chk("fl_dest", bus_if.ms_forward_bus.dest, 0);
    bus_if.pms_to_ms_bus = mk_req(LD_LW, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0000_4004);
    bus_if.data_data_ok  = 1'b1;
    bus_if.data_rdata    = 32'h0000DEAD;
    step();
    bus_if.pms_to_ms_bus = '0;
    bus_if.data_data_ok  = 1'b0;
    #1;
    chk("fl_cancel0", dut.cancel_cnt_q, 0);
    chk("fl_dropped", bus_if.ms_to_ws_bus.valid, 0);
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h00001234;
    #1;
    chk("fl_valid", bus_if.ms_to_ws_bus.valid, 1);
    chk("fl_result", bus_if.ms_to_ws_bus.final_result, 32'h1234);
    step();
    bus_if.data_data_ok = 1'b0;

    // flush with a load waiting and another request accepted upstream: two orphans
    bus_if.pms_to_ms_bus = mk_req(LD_LW, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0000_5000);
    step();
    bus_if.pms_to_ms_bus = mk_req(LD_LW, 1'b1, 1'b0, 5'd6, 32'h0, 32'h0000_5004);
    bus_if.pipeline_flush.flush = 1'b1;
    step();
    bus_if.pms_to_ms_bus = '0;
    bus_if.pipeline_flush.flush = 1'b0;
    #1;
    chk("fl2_cancel2", dut.cancel_cnt_q, 2);
    bus_if.data_data_ok = 1'b1;
    step();
    step();
    bus_if.data_data_ok = 1'b0;
    #1;
    chk("fl2_cancel0", dut.cancel_cnt_q, 0);

    // exception: no wait, rf_we suppressed
    req                     = mk_req(LD_LW, 1'b1, 1'b0, 5'd8, 32'h0, 32'h0000_6001);
    req.req_ok              = 1'b0;
    req.exception.ex        = 1'b1;
    req.exception.exccode   = 5'd4;
    bus_if.pms_to_ms_bus    = req;
    step();
    bus_if.pms_to_ms_bus = '0;
    #1;
    chk("ex_valid", bus_if.ms_to_ws_bus.valid, 1);
    chk("ex_rf_we", bus_if.ms_to_ws_bus.rf_we, 0);
    chk("ex_wr_dis", bus_if.ms_wr_disable, 1);
    chk("ex_code", bus_if.ms_to_ws_bus.exception.exccode, 4);
    step();
    chk("ex_wr_dis_clr", bus_if.ms_wr_disable, 0);

    // non-memory mfc0 passes in one cycle
    req                  = mk_req(LD_LW, 1'b0, 1'b0, 5'd10, 32'h0000_0055, 32'h0);
    req.c0_op            = 3'b100;
    bus_if.pms_to_ms_bus = req;
    step();
    bus_if.pms_to_ms_bus = '0;
    #1;
    chk("alu_valid", bus_if.ms_to_ws_bus.valid, 1);
    chk("alu_result", bus_if.ms_to_ws_bus.final_result, 32'h55);
    chk("alu_mfc0", bus_if.ms_forward_bus.op_mfc0, 1);
    step();
    chk("alu_left", bus_if.ms_to_ws_bus.valid, 0);

    // reset during a pending load with one orphan outstanding
    bus_if.pms_to_ms_bus = mk_req(LD_LW, 1'b1, 1'b0, 5'd11, 32'h0, 32'h0000_7000);
    step();
    bus_if.pms_to_ms_bus = '0;
    bus_if.pipeline_flush.flush = 1'b1;
    step();
    bus_if.pipeline_flush.flush = 1'b0;
    bus_if.pms_to_ms_bus = mk_req(LD_LW, 1'b1, 1'b0, 5'd12, 32'h0, 32'h0000_7004);
    step();
    bus_if.pms_to_ms_bus = '0;
    #1;
    chk("rs_pre_cancel", dut.cancel_cnt_q, 1);
    chk("rs_pre_pending", bus_if.ms_forward_bus.load_pending, 1);
    reset = 1'b1;
    step();
    chk("rs_ws_valid", bus_if.ms_to_ws_bus.valid, 0);
    chk("rs_cancel", dut.cancel_cnt_q, 0);
    chk("rs_pending", bus_if.ms_forward_bus.load_pending, 0);
    chk("rs_dest", bus_if.ms_forward_bus.dest, 0);
    chk("rs_allowin", bus_if.ms_allowin, 1);
    chk("rs_wr_dis", bus_if.ms_wr_disable, 0);
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
